adc_scan_sequencer: RTL

ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

---
 rtl/adc_scan_pkg.sv | 24 ++
 rtl/adc_scan_timer.sv | 27 ++
 rtl/adc_scan_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/adc_scan_pkg.sv
// Shared FSM state type, data/channel widths and command bit positions for the ADC scan sequencer.
package adc_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_STORE = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam int ADC_DATA_W  = 12;
    localparam int ADC_NB_CH   = 4;

    localparam int CMD_START   = 0;
    localparam int CMD_CONT    = 1;
    localparam int CMD_LAST_LO = 2;
    localparam int CMD_LAST_HI = 3;

    function automatic logic [ADC_NB_CH-1:0] channel_onehot(input logic [1:0] ch);
        return ADC_NB_CH'(1) << ch;
    endfunction

endpackage

// File: rtl/adc_scan_timer.sv
// Down-counter shared by the conversion timeout and the inter-scan gap; saturates at zero.
module adc_scan_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/adc_scan_sequencer.sv
// Scans channels 0..last through the ADC serial core and strobes each result to the CPU PIO.
// Define ADC_SCAN_AVG_EN to convert every channel four times and report the average.
module adc_scan_sequencer
    import adc_scan_pkg::*;
#(
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int SCAN_GAP_CYCLES = 16
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    input  logic [3:0]            pi_adc_cmd,
    output logic                  po_conv_req,
    output logic [1:0]            po_conv_ch,
    input  logic                  pi_conv_ack,
    input  logic                  pi_conv_done,
    input  logic [ADC_DATA_W-1:0] pi_conv_data,
    output logic [ADC_DATA_W-1:0] po_adc_data,
    output logic [ADC_NB_CH-1:0]  po_adc_channel_data_valid,
    output logic                  po_busy,
    output logic                  po_timeout
);

    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GAP_W = (SCAN_GAP_CYCLES > 1) ? $clog2(SCAN_GAP_CYCLES) : 1;
    localparam int TMR_W = (TO_W > GAP_W) ? TO_W : GAP_W;
    localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD     = TMR_W'(SCAN_GAP_CYCLES - 1);

    state_t                state, state_next;
    logic                  start_low, start_rise;
    logic                  continuous;
    logic [1:0]            last_ch, channel;
    logic                  done_pending, done_eff, last_sample;
    logic [ADC_DATA_W-1:0] held_data, data_eff, adc_data;
    logic                  timer_load, timer_enable, timer_zero;
    logic [TMR_W-1:0]      timer_value;

    // start_low is the edge history: it reads 0 after reset, so a start held through reset never fires
    assign start_rise = pi_adc_cmd[CMD_START] && start_low;
    assign done_eff   = pi_conv_done || done_pending;
    assign data_eff   = done_pending ? held_data : pi_conv_data;

    assign timer_enable = (state == ST_WAIT) || (state == ST_GAP);

    adc_scan_timer #(.WIDTH(TMR_W)) u_timer (
        .clk        (clk_clk),
        .reset      (reset_reset),
        .load       (timer_load),
        .load_value (timer_value),
        .enable     (timer_enable),
        .zero       (timer_zero)
    );

`ifdef ADC_SCAN_AVG_EN
    localparam int ACC_W = ADC_DATA_W + 2;
    logic [1:0]       sample_cnt;
    logic [ACC_W-1:0] acc, avg_sum;
    assign avg_sum     = acc + ACC_W'(data_eff);
    assign last_sample = (sample_cnt == 2'd3);
`else
    assign last_sample = 1'b1;
`endif

    always_comb begin
        state_next  = state;
        timer_load  = 1'b0;
        timer_value = '0;
        po_timeout  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_rise) state_next = ST_REQ;
            end
            ST_REQ: begin
                if (pi_conv_ack) begin
                    state_next  = ST_WAIT;
                    timer_load  = 1'b1;
                    timer_value = TIMEOUT_LOAD;
                end
            end
            ST_WAIT: begin
                if (done_eff) begin
                    state_next = last_sample ? ST_STORE : ST_REQ;
                end else if (timer_zero) begin
                    state_next = ST_IDLE;
                    po_timeout = 1'b1;
                end
            end
            ST_STORE: begin
                if (channel != last_ch) begin
                    state_next = ST_REQ;
                end else if (continuous && pi_adc_cmd[CMD_START]) begin
                    state_next  = ST_GAP;
                    timer_load  = 1'b1;
                    timer_value = GAP_LOAD;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (!pi_adc_cmd[CMD_START]) state_next = ST_IDLE;
                else if (timer_zero)        state_next = ST_REQ;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // An ack that arrives together with done parks the result so the first WAIT cycle consumes it
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state        <= ST_IDLE;
            start_low    <= 1'b0;
            continuous   <= 1'b0;
            last_ch      <= '0;
            channel      <= '0;
            done_pending <= 1'b0;
            held_data    <= '0;
        end else begin
            state     <= state_next;
            start_low <= ~pi_adc_cmd[CMD_START];
            case (state)
                ST_IDLE: begin
                    if (start_rise) begin
                        channel    <= '0;
                        continuous <= pi_adc_cmd[CMD_CONT];
                        last_ch    <= pi_adc_cmd[CMD_LAST_HI:CMD_LAST_LO];
                    end
                end
                ST_REQ: begin
                    done_pending <= pi_conv_ack && pi_conv_done;
                    if (pi_conv_ack && pi_conv_done) held_data <= pi_conv_data;
                end
                ST_WAIT:  done_pending <= 1'b0;
                ST_STORE: if (channel != last_ch) channel <= channel + 2'd1;
                ST_GAP:   if (state_next == ST_REQ) channel <= '0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            adc_data <= '0;
`ifdef ADC_SCAN_AVG_EN
            acc        <= '0;
            sample_cnt <= '0;
`endif
        end else if ((state == ST_WAIT) && done_eff) begin
`ifdef ADC_SCAN_AVG_EN
            if (last_sample) begin
                adc_data   <= avg_sum[ACC_W-1:2];
                acc        <= '0;
                sample_cnt <= '0;
            end else begin
                acc        <= avg_sum;
                sample_cnt <= sample_cnt + 2'd1;
            end
`else
            adc_data <= data_eff;
`endif
        end
`ifdef ADC_SCAN_AVG_EN
        else if (state == ST_IDLE) begin
            acc        <= '0;
            sample_cnt <= '0;
        end
`endif
    end

    assign po_conv_req               = (state == ST_REQ);
    assign po_conv_ch                = (state == ST_REQ) ? channel : 2'd0;
    assign po_adc_data               = adc_data;
    assign po_adc_channel_data_valid = (state == ST_STORE) ? channel_onehot(channel) : '0;
    assign po_busy                   = (state != ST_IDLE);

endmodule
